// File: rtl/tick_period_meter_if.sv
// tick_period_meter_if
//   Groups the measurement inputs and result outputs of tick_period_meter.
//   master: the block that drives the tick stream and reads results.
//   slave : the meter itself.
// Signals:
//   en      enable, level-sensitive
//   tick_in single-cycle strobe to be measured (clk domain)
//   period  last measured period in clk cycles
//   valid   one-cycle strobe, period/ovf updated this cycle
//   ovf     period saturated at 2^W-1
//   busy    meter state is not IDLE
interface tick_period_meter_if #(
  parameter int W = 16
);
  logic         en;
  logic         tick_in;
  logic [W-1:0] period;
  logic         valid;
  logic         ovf;
  logic         busy;

  modport master (
    output en, tick_in,
    input  period, valid, ovf, busy
  );

  modport slave (
    input  en, tick_in,
    output period, valid, ovf, busy
  );
endinterface

// File: rtl/tick_period_meter.sv
// tick_period_meter
//   Measures the number of clk cycles between consecutive rising edges of
//   tick_in and reports each period with a one-cycle valid strobe.
// Ports:
//   clk       clock, rising edge
//   rstb      asynchronous active-low reset
//   if_meter  tick_period_meter_if.slave (en, tick_in in; period, valid,
//             ovf, busy out)
module tick_period_meter #(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rstb,
  tick_period_meter_if.slave if_meter
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  state_t       r_state,  w_state_nxt;
  logic [W-1:0] r_cnt,    w_cnt_nxt;
  logic [W-1:0] r_period, w_period_nxt;
  logic         r_ovf,    w_ovf_nxt;
  logic         r_valid,  w_valid_nxt;
  logic         r_busy;
  logic         r_tick_d;
  logic         w_rise;

  // tick_d resets high so a tick already high at reset release is not an edge.
  assign w_rise = if_meter.tick_in & ~r_tick_d;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_ovf_nxt    = r_ovf;
    w_valid_nxt  = 1'b0;

    // Dropping en wins over a coincident edge: partial intervals are discarded.
    if (!if_meter.en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = ARM;
          w_cnt_nxt   = '0;
        end
        ARM: begin
          // First edge only starts the interval; nothing to report yet.
          if (w_rise) begin
            w_state_nxt = MEASURE;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            w_period_nxt = r_cnt;
            w_ovf_nxt    = (r_cnt == CNT_MAX);
            w_valid_nxt  = 1'b1;
            w_cnt_nxt    = CNT_ONE;
          end else if (r_cnt != CNT_MAX) begin
            // Saturate rather than wrap so long gaps still flag ovf.
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_tick_d <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_ovf    <= w_ovf_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_tick_d <= if_meter.tick_in;
    end
  end

  assign if_meter.period = r_period;
  assign if_meter.ovf    = r_ovf;
  assign if_meter.valid  = r_valid;
  assign if_meter.busy   = r_busy;

endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter
//   Directed bench for tick_period_meter. Three instances (W=16, W=4, W=8)
//   share the same en/tick_in stimulus; each scenario checks the instance
//   whose width makes the behaviour of interest visible.
module tb_tick_period_meter;

  logic clk;
  logic rstb;
  logic en;
  logic tick;

  int n_total = 0;
  int n_bad   = 0;

  tick_period_meter_if #(.W(16)) if16 ();
  tick_period_meter_if #(.W(4))  if4  ();
  tick_period_meter_if #(.W(8))  if8  ();

  assign if16.en = en;  assign if16.tick_in = tick;
  assign if4.en  = en;  assign if4.tick_in  = tick;
  assign if8.en  = en;  assign if8.tick_in  = tick;

  tick_period_meter #(.W(16)) dut16 (.clk(clk), .rstb(rstb), .if_meter(if16.slave));
  tick_period_meter #(.W(4))  dut4  (.clk(clk), .rstb(rstb), .if_meter(if4.slave));
  tick_period_meter #(.W(8))  dut8  (.clk(clk), .rstb(rstb), .if_meter(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // g-1 low cycles then one high cycle; the caller checks the result that
  // the final edge produces.
  task automatic tick_gap(input int g);
    for (int i = 0; i < g - 1; i++) begin
      tick = 1'b0;
      cyc();
      check("gap_valid16", 32'(if16.valid), 0);
      check("gap_valid4",  32'(if4.valid),  0);
      check("gap_valid8",  32'(if8.valid),  0);
    end
    tick = 1'b1;
    cyc();
  endtask

  int gaps[$];
  int g;
  int exp8;

  initial begin
    rstb = 1'b0;
    en   = 1'b0;
    tick = 1'b0;
    cyc();
    cyc();
    check("rst_period", 32'(if16.period), 0);
    check("rst_valid",  32'(if16.valid),  0);
    check("rst_ovf",    32'(if16.ovf),    0);
    check("rst_busy",   32'(if16.busy),   0);
    rstb = 1'b1;
    cyc();
    check("idle_busy", 32'(if16.busy), 0);

    // M=10 tick stream (max_tick of a mod-10 counter starting at 0).
    en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick = ((c % 10) == 9);
      cyc();
      if (c == 0) check("m10_busy_rise", 32'(if16.busy), 1);
      check("m10_valid", 32'(if16.valid), 32'(((c % 10) == 9) && (c >= 19)));
      if (((c % 10) == 9) && (c >= 19)) begin
        check("m10_period", 32'(if16.period), 10);
        check("m10_ovf",    32'(if16.ovf),    0);
      end
    end

    // Tick high through reset release is not an edge; then 1,0,1,0 toggling.
    rstb = 1'b0;
    tick = 1'b1;
    cyc();
    check("rst2_busy", 32'(if16.busy), 0);
    rstb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("hi_rel_valid", 32'(if16.valid), 0);
    end
    for (int c = 0; c < 20; c++) begin
      tick = c[0];
      cyc();
      check("tog_valid", 32'(if16.valid), 32'(c[0] && (c >= 3)));
      if (c[0] && (c >= 3)) check("tog_period", 32'(if16.period), 2);
    end

    // W=4 saturation and its boundaries.
    en   = 1'b0;
    tick = 1'b0;
    cyc();
    en = 1'b1;
    tick_gap(3);
    check("w4_arm_valid", 32'(if4.valid), 0);
    gaps = '{20, 15, 14, 7};
    foreach (gaps[k]) begin
      g = gaps[k];
      tick_gap(g);
      check("w4_valid",   32'(if4.valid),  1);
      check("w4_period",  32'(if4.period), (g > 15) ? 15 : g);
      check("w4_ovf",     32'(if4.ovf),    32'(g >= 15));
      check("w16_period", 32'(if16.period), g);
    end

    // en dropped for one cycle together with a rise.
    en   = 1'b0;
    tick = 1'b0;
    cyc();
    en = 1'b1;
    tick_gap(3);
    tick_gap(10);
    check("en_pre_valid",  32'(if16.valid),  1);
    check("en_pre_period", 32'(if16.period), 10);
    for (int i = 0; i < 4; i++) begin
      tick = 1'b0;
      cyc();
    end
    en   = 1'b0;
    tick = 1'b1;
    cyc();
    check("en_drop_valid",  32'(if16.valid),  0);
    check("en_drop_period", 32'(if16.period), 10);
    check("en_drop_busy",   32'(if16.busy),   0);
    en   = 1'b1;
    tick = 1'b0;
    cyc();
    check("en_back_busy", 32'(if16.busy), 1);
    tick_gap(4);
    check("rearm_valid",  32'(if16.valid),  0);
    check("rearm_period", 32'(if16.period), 10);
    tick_gap(6);
    check("after_valid",  32'(if16.valid),  1);
    check("after_period", 32'(if16.period), 6);

    // Async reset straight after a saturated result.
    tick_gap(16);
    check("pre_rst_valid4", 32'(if4.valid),  1);
    check("pre_rst_ovf4",   32'(if4.ovf),    1);
    check("pre_rst_per16",  32'(if16.period), 16);
    #1;
    rstb = 1'b0;
    en   = 1'b0;
    tick = 1'b0;
    #1;
    check("arst_valid4",  32'(if4.valid),   0);
    check("arst_ovf4",    32'(if4.ovf),     0);
    check("arst_period4", 32'(if4.period),  0);
    check("arst_busy4",   32'(if4.busy),    0);
    check("arst_per16",   32'(if16.period), 0);
    check("arst_busy16",  32'(if16.busy),   0);
    rstb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_rst_busy", 32'(if16.busy), 0);
    end
    en = 1'b1;
    cyc();
    check("post_rst_busy_en", 32'(if16.busy), 1);

    // W=8 spacing 2..300 against min(interval, 255).
    tick_gap(3);
    check("w8_arm_valid", 32'(if8.valid), 0);
    gaps = '{254, 255, 256, 2, 300};
    for (int i = 0; i < 25; i++) gaps.push_back(int'($urandom_range(300, 2)));
    foreach (gaps[k]) begin
      g    = gaps[k];
      exp8 = (g > 255) ? 255 : g;
      tick_gap(g);
      check("w8_valid",    32'(if8.valid),  1);
      check("w8_period",   32'(if8.period), exp8);
      check("w8_ovf",      32'(if8.ovf),    32'(g >= 255));
      check("w8_period16", 32'(if16.period), g);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the spacing, in `clk` cycles, between consecutive rising edges of a synchronous tick input. Typical sources are `max_tick` from the mod-M counters or any other single-cycle strobe in the `clk` domain. The block is the receiving end of a tick generator. Verification and baud/rate-detect logic use it to recover M from a running tick stream. It measures continuously while enabled and reports every period with a one-cycle `valid` strobe.

## Interface
- `W`, 16: width of the period counter and result; maximum reportable period is 2^W-1.
- `clk`  in  1  clock; all logic on rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `en`  in  1  measurement enable; level-sensitive.
- `tick_in`  in  1  tick to measure; synchronous to `clk`, no synchronizer inside.
- `period`  out  W  last measured period in cycles; held between results.
- `valid`  out  1  one-cycle strobe: `period` and `ovf` updated this cycle.
- `ovf`  out  1  qualifies `valid`: measured interval reached/exceeded 2^W-1, `period` saturated.
- `busy`  out  1  high when state is not IDLE.

## Operation
- Edge detect: `rise = tick_in & ~tick_d`, where `tick_d` is `tick_in` delayed one cycle. `tick_d` resets to 1, so a tick high at reset release is not an edge.
- Period definition: number of `clk` rising edges from one `rise` cycle to the next.
  - A tick high one cycle in every M gives M.
  - Minimum reportable period is 2, since `tick_in` must be low between edges.
- States:
  - IDLE: counter held at 0. `rise` is ignored. Goes to ARM when `en=1`.
  - ARM: waiting for the first edge. On `rise`, set `cnt<=1` and go to MEASURE. No result is reported for this edge.
  - MEASURE, no `rise`: `cnt<=cnt+1`, saturating at 2^W-1.
  - MEASURE, `rise`: `period<=cnt`, `ovf<=(cnt==2^W-1)`, `valid<=1`, `cnt<=1`. Stay in MEASURE.
- `en=0` in any state: next state is IDLE and `cnt<=0`. This has priority over `rise`, and no `valid` is produced that cycle.
- `en` returning to 1 always restarts from ARM. A partial interval is never reported.
- Arithmetic: `cnt` is W bits and unsigned. Saturation is sticky until the next `rise` or leaving MEASURE; the counter never wraps to 0.
- `period` and `ovf` change only on `valid` cycles, or on reset.

## Timing
- Reset values: `period=0`, `valid=0`, `ovf=0`, `busy=0`, state=IDLE, `cnt=0`, `tick_d=1`.
- `busy` is registered: it rises the cycle after `en` is first sampled high, and falls the cycle after `en` is sampled low.
- Result latency: `valid`, `period` and `ovf` are registered. They appear the cycle after the terminating `rise` cycle.
- `valid` is never high two cycles in a row, because of the min period of 2.
- `en` falling in the same cycle as a `rise` in MEASURE: no `valid`, and `period` keeps its previous value.
- Reset mid-measurement: all outputs return to reset values immediately (async). Measurement resumes via ARM once `rstb` is high and `en=1`.
- `tick_in` held high: one `rise` only. The count then saturates, and `ovf` is reported only at the next edge.

## Test plan
- Directed: `en=1`, drive `tick_in` from `modm_counter_2` `max_tick` with M=10.
  - First `valid` comes at the second edge, with `period=10`, `ovf=0`.
  - A `valid` then follows every 10 cycles.
- Directed: `tick_in` toggling 1,0,1,0… gives `period=2` on every `valid`. Also check `tick_in` high at reset release produces no edge.
- Directed: W=4, edges 20 cycles apart → `period=15`, `ovf=1`. Then edges 7 apart → `period=7`, `ovf=0`.
- Directed: drop `en` for 1 cycle mid-interval, coinciding with a `rise`.
  - No `valid` that cycle; `period` unchanged.
  - The next result comes only after two further edges (re-arm).
- Directed: assert `rstb=0` asynchronously between edges. Check all outputs go to 0 immediately and `busy` stays 0 until `en` is sampled high.
- Random: random tick spacing 2..300 with W=8. A scoreboard compares each `period`/`ovf` against the reference interval, min(interval, 255).
